// File: rtl/jpeg_block_pkg.sv
// Shared constants, state encodings and the zigzag-to-raster table for the RLE block assembler.
package jpeg_block_pkg;
   localparam int BLOCK_SIZE = 64;
   localparam int RUN_W      = 4;
   localparam int ZRL_RUN    = 15;
   localparam int POS_W      = 7;

   typedef logic [1:0] state_t;
   localparam state_t ST_DC   = 2'd0;
   localparam state_t ST_AC   = 2'd1;
   localparam state_t ST_HOLD = 2'd2;

   // Entry t gives the row-major raster index of zigzag scan position t.
   localparam logic [5:0] ZIGZAG_TO_RASTER [BLOCK_SIZE] = '{
      6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
      6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
      6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
      6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
      6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
      6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
      6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
      6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
   };
endpackage

// File: rtl/zigzag_rom.sv
// Combinational zigzag-to-raster index lookup; only built when ZIGZAG_REORDER_EN is defined.
`ifdef ZIGZAG_REORDER_EN
module zigzag_rom
   import jpeg_block_pkg::*;
(
   input  logic [5:0] zz_idx,
   output logic [5:0] raster_idx
);
   assign raster_idx = ZIGZAG_TO_RASTER[zz_idx];
endmodule
`endif

// File: rtl/rle_block_assembler.sv
// Expands (run, coefficient) symbols into 64-entry blocks with per-component DC prediction.
// ZIGZAG_REORDER_EN defined: blocks leave in raster order; otherwise in zigzag scan order.
module rle_block_assembler
   import jpeg_block_pkg::*;
#(
   parameter int COEF_W   = 12,
   parameter int NUM_COMP = 3,
   parameter int COMP_W   = 2
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         restart,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [RUN_W-1:0]             in_run,
   input  logic [COEF_W-1:0]            in_coef,
   input  logic                         in_eob,
   input  logic [COMP_W-1:0]            in_comp,
   output logic                         blk_valid,
   input  logic                         blk_ready,
   output logic [BLOCK_SIZE*COEF_W-1:0] blk_data,
   output logic [COMP_W-1:0]            blk_comp,
   output logic                         blk_err
);
   state_t             state_reg;
   logic [POS_W-1:0]   pos_reg;
   logic [COEF_W-1:0]  buf_reg  [BLOCK_SIZE];
   logic [COEF_W-1:0]  pred_reg [NUM_COMP];
   logic [COMP_W-1:0]  comp_reg;
   logic               err_reg;

   logic               accept;
   logic [COMP_W-1:0]  comp_idx;
   logic [COEF_W-1:0]  pred_sel;
   logic [COEF_W-1:0]  dc_val;
   logic [POS_W-1:0]   t_full;
   logic [5:0]         wr_addr;

   assign in_ready  = (state_reg != ST_HOLD);
   assign blk_valid = (state_reg == ST_HOLD);
   assign blk_comp  = comp_reg;
   assign blk_err   = err_reg;
   assign accept    = in_valid && in_ready;

   // Out-of-range component indices fall back to component 0.
   assign comp_idx = (int'(in_comp) < NUM_COMP) ? in_comp : '0;
   // A restart on the DC beat clears the predictor before it is used.
   assign pred_sel = restart ? '0 : pred_reg[comp_idx];
   assign dc_val   = pred_sel + in_coef;
   assign t_full   = pos_reg + POS_W'(in_run);

`ifdef ZIGZAG_REORDER_EN
   zigzag_rom u_zigzag_rom (
      .zz_idx     (t_full[5:0]),
      .raster_idx (wr_addr)
   );
`else
   assign wr_addr = t_full[5:0];
`endif

   generate
      for (genvar gi = 0; gi < BLOCK_SIZE; gi++) begin : g_out
         assign blk_data[gi*COEF_W +: COEF_W] = buf_reg[gi];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg <= ST_DC;
         pos_reg   <= '0;
         comp_reg  <= '0;
         err_reg   <= 1'b0;
         for (int k = 0; k < BLOCK_SIZE; k++) buf_reg[k] <= '0;
         for (int k = 0; k < NUM_COMP; k++) pred_reg[k] <= '0;
      end else begin
         if (restart) begin
            for (int k = 0; k < NUM_COMP; k++) pred_reg[k] <= '0;
         end
         case (state_reg)
            ST_DC: begin
               if (accept) begin
                  for (int k = 1; k < BLOCK_SIZE; k++) buf_reg[k] <= '0;
                  comp_reg <= comp_idx;
                  err_reg  <= 1'b0;
                  if (in_eob) begin
                     buf_reg[0] <= pred_sel;
                     state_reg  <= ST_HOLD;
                  end else begin
                     buf_reg[0]         <= dc_val;
                     pred_reg[comp_idx] <= dc_val;
                     pos_reg            <= POS_W'(1);
                     state_reg          <= ST_AC;
                  end
               end
            end
            ST_AC: begin
               if (accept) begin
                  if (in_eob) begin
                     state_reg <= ST_HOLD;
                  end else if (t_full > POS_W'(BLOCK_SIZE - 1)) begin
                     err_reg   <= 1'b1;
                     state_reg <= ST_HOLD;
                  end else begin
                     buf_reg[wr_addr] <= in_coef;
                     pos_reg          <= t_full + POS_W'(1);
                     if (t_full == POS_W'(BLOCK_SIZE - 1)) state_reg <= ST_HOLD;
                  end
               end
            end
            ST_HOLD: begin
               if (blk_ready) begin
                  err_reg   <= 1'b0;
                  pos_reg   <= '0;
                  state_reg <= ST_DC;
               end
            end
            default: state_reg <= ST_DC;
         endcase
      end
   end
endmodule
